// File: rtl/cmd_frame_rx_pkg.sv
// Shared definitions for the framed-command receiver: FSM state encoding,
// default header bytes and the payload index width helper.
package cmd_frame_pkg;

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_PAY  = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  localparam logic [7:0] HDR0_DEFAULT = 8'hEB;
  localparam logic [7:0] HDR1_DEFAULT = 8'h90;

  // A single-byte payload still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_frame_rx_if.sv
// Byte-stream input and staged-command handshake of cmd_frame_rx.
// The receiver itself uses the slave view; the source/consumer side uses master.
interface cmd_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 8
);

  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic                       cmd_ready_clear;
  logic [8*PAYLOAD_BYTES-1:0] cmd_data;
  logic                       cmd_ready;
  logic                       chk_err;
  logic                       overrun_err;
  logic                       timeout_err;
  logic [7:0]                 frame_cnt;

  modport master (
    output rx_data, rx_valid, cmd_ready_clear,
    input  cmd_data, cmd_ready, chk_err, overrun_err, timeout_err, frame_cnt
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready_clear,
    output cmd_data, cmd_ready, chk_err, overrun_err, timeout_err, frame_cnt
  );

endinterface

// File: rtl/cmd_frame_rx_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is in progress and
// flags the cycle in which the count would reach TIMEOUT_CYCLES.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Expiry overrides a same-cycle kick, so the aborting edge also clears the count.
  assign expire = run && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_inc;
    if (!run || kick || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_frame_rx.sv
// Frame assembler: header hunt, payload shift/sum, checksum verify, and a
// single-entry staging register handed to the update controller.
module cmd_frame_rx
  import cmd_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 8,
  parameter logic [7:0] HDR0           = HDR0_DEFAULT,
  parameter logic [7:0] HDR1           = HDR1_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  cmd_frame_rx_if.slave bus
);

  localparam int W     = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = idx_width(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic [W-1:0]     cmd_data_q, cmd_data_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             chk_err_q, chk_err_d;
  logic             overrun_err_q, overrun_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             commit;
  logic             timer_run;
  logic             expire;

  assign timer_run = (state_q != S_HDR0);

  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (timer_run),
    .kick  (bus.rx_valid),
    .expire(expire)
  );

  always_comb begin : fsm_comb
    state_d       = state_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    shadow_d      = shadow_q;
    commit        = 1'b0;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    if (expire) begin
      // A byte arriving in the expiry cycle belongs to the aborted frame and is dropped.
      timeout_err_d = 1'b1;
      state_d       = S_HDR0;
      idx_d         = '0;
      sum_d         = '0;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_HDR0: begin
          if (bus.rx_data == HDR0) state_d = S_HDR1;
        end
        S_HDR1: begin
          if (bus.rx_data == HDR1) begin
            state_d = S_PAY;
            idx_d   = '0;
            sum_d   = '0;
          end else if (bus.rx_data != HDR0) begin
            state_d = S_HDR0;
          end
        end
        S_PAY: begin
          shadow_d = (shadow_q << 8) | W'(bus.rx_data);
          sum_d    = sum_q + bus.rx_data;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_CHK;
        end
        S_CHK: begin
          if (bus.rx_data == sum_q) commit = 1'b1;
          else                      chk_err_d = 1'b1;
          state_d = S_HDR0;
        end
        default: state_d = S_HDR0;
      endcase
    end
  end

  // A new commit beats a same-cycle clear so the consumer never sees a gap.
  always_comb begin : stage_comb
    cmd_data_d    = cmd_data_q;
    cmd_ready_d   = cmd_ready_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_err_d = 1'b0;

    if (commit) begin
      if (!cmd_ready_q || bus.cmd_ready_clear) begin
        cmd_data_d  = shadow_q;
        cmd_ready_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (bus.cmd_ready_clear) begin
      cmd_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_HDR0;
      idx_q         <= '0;
      sum_q         <= '0;
      shadow_q      <= '0;
      cmd_data_q    <= '0;
      cmd_ready_q   <= 1'b0;
      frame_cnt_q   <= '0;
      chk_err_q     <= 1'b0;
      overrun_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      shadow_q      <= shadow_d;
      cmd_data_q    <= cmd_data_d;
      cmd_ready_q   <= cmd_ready_d;
      frame_cnt_q   <= frame_cnt_d;
      chk_err_q     <= chk_err_d;
      overrun_err_q <= overrun_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.cmd_data    = cmd_data_q;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.chk_err     = chk_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
